// File: rtl/pc_gen_pkg.sv
// Shared encodings and default vectors for the fetch PC generator.
package pc_gen_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_JMP  = 2'b10;
    localparam logic [1:0] SEL_EXC  = 2'b11;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'hBFC0_0380;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle: redirect inputs from branch/jump resolution and the
// fetch request towards instruction memory.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_ready;
    logic [1:0]        redir_sel;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic              halt;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_valid_o;
    logic              flush_o;
    logic              misalign_o;
    logic [ADDR_W-1:0] badaddr_o;

    // PC generator side
    modport master (
        input  fetch_ready, redir_sel, branch_tgt, jump_tgt, halt,
        output pc_o, pc_valid_o, flush_o, misalign_o, badaddr_o
    );

    // Fetch / resolution logic side
    modport slave (
        output fetch_ready, redir_sel, branch_tgt, jump_tgt, halt,
        input  pc_o, pc_valid_o, flush_o, misalign_o, badaddr_o
    );
endinterface

// File: rtl/pc_target_mux.sv
// Redirect target select with alignment trap. A misaligned branch/jump
// target is replaced by the exception vector; the raw target is still
// exported so the caller can capture the bad address.
module pc_target_mux
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC    = DEF_EXC_VEC[ADDR_W-1:0],
    parameter int                ALIGN_BITS = 2
) (
    input  logic [1:0]        i_redir_sel,
    input  logic [ADDR_W-1:0] i_branch_tgt,
    input  logic [ADDR_W-1:0] i_jump_tgt,
    output logic              o_redir,
    output logic [ADDR_W-1:0] o_tgt,
    output logic              o_misalign,
    output logic [ADDR_W-1:0] o_raw_tgt
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [ADDR_W-1:0] w_sel_tgt;
    logic              w_is_flow;

    // Pick the candidate and flag low-bit misalignment on branch/jump only
    always_comb begin
        w_sel_tgt  = (i_redir_sel == SEL_JMP) ? i_jump_tgt : i_branch_tgt;
        w_is_flow  = (i_redir_sel == SEL_BR) || (i_redir_sel == SEL_JMP);
        o_redir    = (i_redir_sel != SEL_NONE);
        o_misalign = w_is_flow && ((w_sel_tgt & ALIGN_MASK) != '0);
        o_tgt      = (o_misalign || (i_redir_sel == SEL_EXC)) ? EXC_VEC : w_sel_tgt;
        o_raw_tgt  = w_sel_tgt;
    end

endmodule

// File: rtl/pc_gen.sv
// Architectural fetch PC generator.
//
//   state  | meaning
//   BOOT   | just out of reset, pc=RESET_VEC, no fetch issued, redirects ignored
//   RUN    | issuing pc_o; redirect > halt > fetch_ready advance > hold
//   HALTED | no fetch issued, pc held; redirect or halt=0 resumes RUN
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = DEF_RESET_VEC[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] EXC_VEC    = DEF_EXC_VEC[ADDR_W-1:0],
    parameter int                INC        = 4,
    parameter int                ALIGN_BITS = 2
) (
    input logic      clk,
    input logic      rst_n,
    pc_gen_if.master io_fetch
);

    pc_state_e         r_state;
    pc_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_flush;
    logic              w_flush_nxt;
    logic              r_misalign;
    logic              w_misalign_nxt;
    logic [ADDR_W-1:0] r_badaddr;
    logic [ADDR_W-1:0] w_badaddr_nxt;

    logic              w_redir;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_tgt_misalign;
    logic [ADDR_W-1:0] w_raw_tgt;

    pc_target_mux #(
        .ADDR_W     (ADDR_W),
        .EXC_VEC    (EXC_VEC),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_mux (
        .i_redir_sel  (io_fetch.redir_sel),
        .i_branch_tgt (io_fetch.branch_tgt),
        .i_jump_tgt   (io_fetch.jump_tgt),
        .o_redir      (w_redir),
        .o_tgt        (w_tgt),
        .o_misalign   (w_tgt_misalign),
        .o_raw_tgt    (w_raw_tgt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC and status flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_VEC;
            r_valid    <= 1'b0;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            r_badaddr  <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_flush    <= w_flush_nxt;
            r_misalign <= w_misalign_nxt;
            r_badaddr  <= w_badaddr_nxt;
        end
    end

    // Next state and next PC; redirect beats halt beats sequential advance
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_flush_nxt    = 1'b0;
        w_misalign_nxt = 1'b0;
        w_badaddr_nxt  = r_badaddr;
        unique case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN, HALTED: begin
                if (w_redir) begin
                    w_state_nxt    = RUN;
                    w_pc_nxt       = w_tgt;
                    w_flush_nxt    = 1'b1;
                    w_misalign_nxt = w_tgt_misalign;
                    if (w_tgt_misalign) begin
                        w_badaddr_nxt = w_raw_tgt;
                    end
                end else if (r_state == RUN) begin
                    if (io_fetch.halt) begin
                        w_state_nxt = HALTED;
                    end else if (io_fetch.fetch_ready) begin
                        w_pc_nxt = r_pc + ADDR_W'(INC);
                    end
                end else if (!io_fetch.halt) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
        w_valid_nxt = (w_state_nxt == RUN);
    end

    assign io_fetch.pc_o       = r_pc;
    assign io_fetch.pc_valid_o = r_valid;
    assign io_fetch.flush_o    = r_flush;
    assign io_fetch.misalign_o = r_misalign;
    assign io_fetch.badaddr_o  = r_badaddr;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, then randomized traffic against
// a behavioural model of the fetch PC rules.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic clk;
    logic rst_n;

    pc_gen_if #(.ADDR_W(32)) bus32 ();
    pc_gen_if #(.ADDR_W(8))  bus8 ();

    pc_gen u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_fetch (bus32)
    );

    pc_gen #(
        .ADDR_W    (8),
        .RESET_VEC (8'hF0),
        .EXC_VEC   (8'h80)
    ) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_fetch (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        fr;
        logic [1:0]  sel;
        logic [31:0] br;
        logic [31:0] jmp;
        logic        halt;
        logic [31:0] pc;
        logic        vld;
        logic        fl;
        logic        mis;
        logic [31:0] bad;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic fr, logic [1:0] sel, logic [31:0] br, logic [31:0] jmp,
                                logic halt, logic [31:0] pc, logic vld, logic fl, logic mis,
                                logic [31:0] bad);
        vec_t v;
        v.fr = fr; v.sel = sel; v.br = br; v.jmp = jmp; v.halt = halt;
        v.pc = pc; v.vld = vld; v.fl = fl; v.mis = mis; v.bad = bad;
        return v;
    endfunction

    // Behavioural model: mode 0 boot, 1 run, 2 halted
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_flush;
    logic        m_mis;
    logic [31:0] m_bad;

    task automatic model_reset();
        m_mode = 0; m_pc = 32'hBFC0_0000; m_valid = 0; m_flush = 0; m_mis = 0; m_bad = 0;
    endtask

    task automatic model_step(input logic fr, input logic [1:0] sel, input logic [31:0] br,
                              input logic [31:0] jmp, input logic halt);
        logic [31:0] raw;
        m_flush = 0;
        m_mis   = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (sel != 2'd0) begin
            m_flush = 1;
            m_mode  = 1;
            if (sel == 2'd3) begin
                m_pc = 32'hBFC0_0380;
            end else begin
                raw = (sel == 2'd1) ? br : jmp;
                if (raw % 4 != 0) begin
                    m_pc  = 32'hBFC0_0380;
                    m_mis = 1;
                    m_bad = raw;
                end else begin
                    m_pc = raw;
                end
            end
        end else if (m_mode == 1) begin
            if (halt) m_mode = 2;
            else if (fr) m_pc = m_pc + 32'd4;
        end else if (!halt) begin
            m_mode = 1;
        end
        m_valid = (m_mode == 1);
    endtask

    task automatic drive32(input logic fr, input logic [1:0] sel, input logic [31:0] br,
                           input logic [31:0] jmp, input logic halt);
        bus32.fetch_ready = fr;
        bus32.redir_sel   = sel;
        bus32.branch_tgt  = br;
        bus32.jump_tgt    = jmp;
        bus32.halt        = halt;
    endtask

    task automatic check32(input string tag, input logic [31:0] pc, input logic vld,
                           input logic fl, input logic mis, input logic [31:0] bad);
        chk({tag, ".pc"},       bus32.pc_o,              pc);
        chk({tag, ".valid"},    32'(bus32.pc_valid_o),   32'(vld));
        chk({tag, ".flush"},    32'(bus32.flush_o),      32'(fl));
        chk({tag, ".misalign"}, 32'(bus32.misalign_o),   32'(mis));
        chk({tag, ".badaddr"},  bus32.badaddr_o,         bad);
    endtask

    initial begin
        logic [7:0]  e8;
        logic [1:0]  rsel;
        logic [31:0] rbr;
        logic [31:0] rjmp;
        logic        rfr;
        logic        rhalt;
        int          r;

        vq.push_back(mk(1, 2'd1, 32'h8000_0100, 0, 0, 32'hBFC0_0000, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_0004, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_0008, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_000C, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_0010, 1, 0, 0, 0));
        vq.push_back(mk(0, 2'd0, 0, 0, 0, 32'hBFC0_0010, 1, 0, 0, 0));
        vq.push_back(mk(0, 2'd0, 0, 0, 0, 32'hBFC0_0010, 1, 0, 0, 0));
        vq.push_back(mk(0, 2'd0, 0, 0, 0, 32'hBFC0_0010, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_0014, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_0018, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_001C, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_0020, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 1, 32'hBFC0_0020, 0, 0, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 1, 32'hBFC0_0020, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'd3, 0, 0, 1, 32'hBFC0_0380, 1, 1, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hBFC0_0384, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd1, 32'h8000_0100, 32'h1234_5678, 0, 32'h8000_0100, 1, 1, 0, 0));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'h8000_0104, 1, 0, 0, 0));
        vq.push_back(mk(1, 2'd2, 32'h4000_0000, 32'h8000_0102, 0, 32'hBFC0_0380, 1, 1, 1, 32'h8000_0102));
        vq.push_back(mk(1, 2'd1, 32'h8000_0200, 32'h0000_0003, 0, 32'h8000_0200, 1, 1, 0, 32'h8000_0102));
        vq.push_back(mk(0, 2'd0, 0, 0, 0, 32'h8000_0200, 1, 0, 0, 32'h8000_0102));
        vq.push_back(mk(0, 2'd0, 0, 0, 1, 32'h8000_0200, 0, 0, 0, 32'h8000_0102));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'h8000_0200, 1, 0, 0, 32'h8000_0102));
        vq.push_back(mk(1, 2'd2, 0, 32'h8000_0001, 1, 32'hBFC0_0380, 1, 1, 1, 32'h8000_0001));
        vq.push_back(mk(1, 2'd1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 1, 1, 0, 32'h8000_0001));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 32'h8000_0001));
        vq.push_back(mk(1, 2'd0, 0, 0, 0, 32'h0000_0000, 1, 0, 0, 32'h8000_0001));

        rst_n = 1'b0;
        drive32(0, 2'd0, 0, 0, 0);
        bus8.fetch_ready = 1'b1;
        bus8.redir_sel   = 2'd0;
        bus8.branch_tgt  = 8'h0;
        bus8.jump_tgt    = 8'h0;
        bus8.halt        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check32("reset", 32'hBFC0_0000, 0, 0, 0, 0);
        chk("reset8.pc", 32'(bus8.pc_o), 32'h0000_00F0);

        // Release just after an edge; the following edge leaves BOOT
        rst_n = 1'b1;
        #1;
        check32("release", 32'hBFC0_0000, 0, 0, 0, 0);

        for (int k = 0; k < vq.size(); k++) begin
            drive32(vq[k].fr, vq[k].sel, vq[k].br, vq[k].jmp, vq[k].halt);
            @(posedge clk);
            #1;
            check32($sformatf("vec%0d", k), vq[k].pc, vq[k].vld, vq[k].fl, vq[k].mis, vq[k].bad);
            if (k <= 4) begin
                e8 = 8'hF0 + 8'(4 * k);
                chk($sformatf("vec%0d.pc8", k), 32'(bus8.pc_o), 32'(e8));
                chk($sformatf("vec%0d.valid8", k), 32'(bus8.pc_valid_o), 32'd1);
            end
        end

        // Asynchronous reset away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check32("async_rst", 32'hBFC0_0000, 0, 0, 0, 0);
        chk("async_rst.pc8", 32'(bus8.pc_o), 32'h0000_00F0);

        @(posedge clk);
        #1;
        drive32(0, 2'd0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        #1;
        check32("rand_release", m_pc, m_valid, m_flush, m_mis, m_bad);

        for (int c = 0; c < 3000; c++) begin
            r     = int'($urandom_range(0, 15));
            rsel  = (r <= 10) ? 2'd0 : (r <= 12) ? 2'd1 : (r <= 14) ? 2'd2 : 2'd3;
            rbr   = $urandom;
            rjmp  = $urandom;
            if ($urandom_range(0, 1) == 0) rbr[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) rjmp[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rbr = 32'hFFFF_FFF0;
            rfr   = ($urandom_range(0, 3) != 0);
            rhalt = ($urandom_range(0, 9) == 0);
            drive32(rfr, rsel, rbr, rjmp, rhalt);
            model_step(rfr, rsel, rbr, rjmp, rhalt);
            @(posedge clk);
            #1;
            check32($sformatf("rand%0d", c), m_pc, m_valid, m_flush, m_mis, m_bad);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
